gpio_irq_sched: RTL
===================

GPIO_IRQ_SCHED -- requirements
Module: gpio_irq_sched

Interface
REQ-001 Parameter PIN_NUM, default 32, number of GPIO pins scheduled.
REQ-002 Parameter ID_W, default $clog2(PIN_NUM), width of the pin index.
REQ-003 pclk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 preset  input  1  reset, asynchronous and active-high.
REQ-005 trg_i  input  PIN_NUM  per-pin qualified trigger (edge pulse or level); sampled every cycle.
REQ-006 mask_i  input  PIN_NUM  per-pin enable; 1 = pin may be offered.
REQ-007 irq_o  output  1  interrupt request to the CPU.
REQ-008 id_valid_o  output  1  irq_id_o holds a valid offered pin.
REQ-009 id_ready_i  input  1  CPU claim; a handshake completes when id_valid_o and id_ready_i are both 1.
REQ-010 irq_id_o  output  ID_W  index of the offered or claimed pin.
REQ-011 done_i  input  1  one-cycle pulse from the CPU; servicing of the claimed pin is complete.
REQ-012 pend_o  output  PIN_NUM  pending register, for software readback.
REQ-013 busy_o  output  1  1 while in state SERVE.

Function
REQ-014 pend[i] SHALL be set on the edge after any cycle with trg_i[i]=1, regardless of mask_i[i] or FSM state.
REQ-015 pend[i] SHALL be cleared only on the claim handshake for pin i; if trg_i[i]=1 in the claim cycle, set wins and pend[i] stays 1.
REQ-016 FSM states SHALL be IDLE, ARB, OFFER and SERVE.
  - IDLE->ARB when |(pend & mask_i) = 1.
  - ARB->OFFER always; latches the winner into irq_id_o.
  - OFFER->SERVE on the claim handshake.
  - OFFER->IDLE if mask_i[irq_id_o] drops to 0 before the claim; pend is untouched.
  - SERVE->IDLE on done_i=1.
REQ-017 Arbitration in ARB SHALL be round-robin over (pend & mask_i): the search starts at ptr, ptr = last claimed id + 1 with wrap PIN_NUM-1 -> 0, and the lowest index at or after ptr wins.
REQ-018 ptr SHALL update only on the claim handshake; an OFFER abandoned by a mask drop does not advance it.
REQ-019 irq_o and id_valid_o SHALL equal (state==OFFER); busy_o SHALL equal (state==SERVE).
REQ-020 irq_id_o SHALL hold its value through OFFER and SERVE, and SHALL be 0 in IDLE.
REQ-021 Latency: trg_i[i] high in cycle t with the FSM in IDLE and the pin unmasked SHALL give irq_o=1 in cycle t+3 (pend at t+1, ARB at t+2, OFFER at t+3).
REQ-022 id_ready_i outside OFFER and done_i outside SERVE SHALL be ignored.
REQ-023 Only one pin is in service at a time; new triggers during SERVE only accumulate in pend.

Reset
REQ-024 While preset=1: pend=0, ptr=0, state=IDLE, irq_id_o=0, and irq_o, id_valid_o, busy_o are all 0.
REQ-025 Reset asserted mid-OFFER or mid-SERVE SHALL abandon the transaction immediately; pending events are lost.

Structure
REQ-026 Shared package gpio_irq_pkg SHALL hold the state enum typedef and the default PIN_NUM constant.
REQ-027 Round-robin selection SHALL live in sub-module gpio_rr_arb, inputs req/ptr, outputs gnt_id/gnt_vld, purely combinational; FSM, pend and ptr stay in the top.

Verification
REQ-028 Trigger pin 5 for one cycle, mask all 1 -> irq_o=1 three cycles later, irq_id_o=5; claim -> pend_o[5]=0, busy_o=1; done_i -> IDLE.
REQ-029 Pins 3, 7 and 20 pending, ptr=0 -> service order 3, 7, 20; then pin 3 re-triggered while pin 7 is pending -> order 7 before 3.
REQ-030 Pin 31 claimed, then pins 0 and 31 pending -> 0 is offered first (wrap).
REQ-031 trg_i[9]=1 in the same cycle as the claim of pin 9 -> pend_o[9]=1 after the claim; pin 9 is offered again after done_i.
REQ-032 Pin 4 offered, mask_i[4] cleared before the claim -> return to IDLE, pend_o[4]=1, ptr unchanged.
REQ-033 preset pulsed during SERVE with pend=0x0000_0F00 -> all outputs 0 and pend_o=0 on the reset cycle.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared types and defaults for the GPIO interrupt scheduler.
package gpio_irq_pkg;

  localparam int unsigned PIN_NUM_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_OFFER = 2'd2,
    ST_SERVE = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_rr_arb.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, with wrap.
module gpio_rr_arb
  import gpio_irq_pkg::*;
#(
  parameter int unsigned PIN_NUM = PIN_NUM_DEF,
  parameter int unsigned ID_W    = $clog2(PIN_NUM)
) (
  input  logic [PIN_NUM-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_vld_o
);

  localparam int unsigned SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk indices ptr, ptr+1, ... modulo PIN_NUM; first hit wins.
  always_comb begin
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < PIN_NUM; i++) begin
      sum = {1'b0, ptr_i} + SW'(i);
      if (sum >= SW'(PIN_NUM)) begin
        sum = sum - SW'(PIN_NUM);
      end
      idx = sum[ID_W-1:0];
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = idx;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_sched.sv
// GPIO interrupt scheduler: pending capture, round-robin offer, claim/serve handshake.
module gpio_irq_sched
  import gpio_irq_pkg::*;
#(
  parameter int unsigned PIN_NUM = PIN_NUM_DEF,
  parameter int unsigned ID_W    = $clog2(PIN_NUM)
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [PIN_NUM-1:0] trg_i,
  input  logic [PIN_NUM-1:0] mask_i,
  output logic               irq_o,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               done_i,
  output logic [PIN_NUM-1:0] pend_o,
  output logic               busy_o
);

  state_e             state_q, state_d;
  logic [PIN_NUM-1:0] pend_q, pend_d, clr;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               irq_q, irq_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;

  gpio_rr_arb #(
    .PIN_NUM (PIN_NUM),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (pend_q & mask_i),
    .ptr_i     (ptr_q),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        id_d = '0;
        if (|(pend_q & mask_i)) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // Mask may have dropped since IDLE; never offer a pin that is not requesting.
        if (gnt_vld) begin
          state_d = ST_OFFER;
          id_d    = gnt_id;
        end else begin
          state_d = ST_IDLE;
          id_d    = '0;
        end
      end
      ST_OFFER: begin
        if (id_ready_i) begin
          state_d    = ST_SERVE;
          clr[id_q]  = 1'b1;
          ptr_d      = (id_q == ID_W'(PIN_NUM - 1)) ? '0 : id_q + ID_W'(1);
        end else if (!mask_i[id_q]) begin
          state_d = ST_IDLE;
          id_d    = '0;
        end
      end
      ST_SERVE: begin
        if (done_i) begin
          state_d = ST_IDLE;
          id_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = '0;
      end
    endcase
    // A trigger in the claim cycle re-sets the bit being cleared.
    pend_d = (pend_q & ~clr) | trg_i;
    irq_d  = (state_d == ST_OFFER);
    busy_d = (state_d == ST_SERVE);
  end

  assign irq_o      = irq_q;
  assign id_valid_o = irq_q;
  assign busy_o     = busy_q;
  assign irq_id_o   = id_q;
  assign pend_o     = pend_q;

endmodule
